// File: rtl/c_arb_merge_nodata.sv
// N-to-1 round-robin merge for the drive/free handshake; carries no data.
// One transfer is outstanding at a time, and o_select names the upstream port that owns it.
module c_arb_merge_nodata #(
  parameter int unsigned NUM_PORTS = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_PORTS-1:0] i_drive,
  output logic [NUM_PORTS-1:0] o_free,
  output logic                 o_driveNext,
  input  logic                 i_freeNext,
  output logic [NUM_PORTS-1:0] o_select,
  output logic                 o_busy,
  output logic                 o_err
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] pending_q, pending_d;
  idx_t                 last_q, last_d;
  logic [NUM_PORTS-1:0] select_d, free_d, clear;
  logic                 drive_d, busy_d, err_d;

  logic                 found;
  idx_t                 gnt_idx;
  int unsigned          scan;

  // Round-robin search over registered pending, starting just after the last grant
  always_comb begin
    found   = 1'b0;
    gnt_idx = last_q;
    scan    = 0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      scan = 32'(last_q) + i;
      if (scan >= NUM_PORTS) scan = scan - NUM_PORTS;
      if (!found && pending_q[scan[IDX_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = idx_t'(scan);
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    select_d = o_select;
    free_d   = '0;
    clear    = '0;
    drive_d  = 1'b0;
    busy_d   = o_busy;
    err_d    = o_err | (|(i_drive & pending_q));

    case (state_q)
      S_IDLE: begin
        if (i_freeNext) err_d = 1'b1;
        if (found) begin
          state_d  = S_WAIT;
          last_d   = gnt_idx;
          select_d = NUM_PORTS'(1) << gnt_idx;
          drive_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end
      S_WAIT: begin
        if (i_freeNext) begin
          state_d  = S_IDLE;
          free_d   = o_select;
          clear    = o_select;
          select_d = '0;
          busy_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A drive on a port that is already pending is a violation and is dropped
    pending_d = (pending_q & ~clear) | (i_drive & ~pending_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      last_q      <= idx_t'(NUM_PORTS - 1);
      o_select    <= '0;
      o_free      <= '0;
      o_driveNext <= 1'b0;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      last_q      <= last_d;
      o_select    <= select_d;
      o_free      <= free_d;
      o_driveNext <= drive_d;
      o_busy      <= busy_d;
      o_err       <= err_d;
    end
  end

endmodule

// File: tb/tb_c_arb_merge_nodata.sv
// Directed bench for c_arb_merge_nodata with NUM_PORTS=5.
// Outputs are sampled 1ns after each rising edge, and inputs change at that same point.
module tb_c_arb_merge_nodata;

  localparam int unsigned N = 5;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] i_drive;
  logic [N-1:0] o_free;
  logic         o_driveNext;
  logic         i_freeNext;
  logic [N-1:0] o_select;
  logic         o_busy;
  logic         o_err;

  int total = 0;
  int bad   = 0;

  c_arb_merge_nodata #(.NUM_PORTS(N)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_drive    (i_drive),
    .o_free     (o_free),
    .o_driveNext(o_driveNext),
    .i_freeNext (i_freeNext),
    .o_select   (o_select),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn       = 1'b0;
    i_drive    = '0;
    i_freeNext = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  // Output state of an idle arbiter, apart from o_err
  task automatic chk_idle(input string tag);
    chk({tag, "_sel"},  32'(o_select),    32'h0);
    chk({tag, "_busy"}, 32'(o_busy),      32'h0);
    chk({tag, "_drv"},  32'(o_driveNext), 32'h0);
    chk({tag, "_free"}, 32'(o_free),      32'h0);
  endtask

  // From a grant cycle: wait one cycle, free on the next edge, check the o_free pulse
  task automatic free_grant(input string tag, input logic [N-1:0] owner);
    tick();
    i_freeNext = 1'b1;
    tick();
    i_freeNext = 1'b0;
    chk({tag, "_free"}, 32'(o_free),   32'(owner));
    chk({tag, "_sel0"}, 32'(o_select), 32'h0);
    chk({tag, "_bsy0"}, 32'(o_busy),   32'h0);
  endtask

  initial begin
    do_reset();
    chk_idle("rst");
    chk("rst_err", 32'(o_err), 32'h0);

    // Single request on port 2: grant appears two edges after the drive
    i_drive = 5'b00100;
    tick();
    i_drive = '0;
    chk("s1_drv_lat", 32'(o_driveNext), 32'h0);
    tick();
    chk("s1_drv", 32'(o_driveNext), 32'h1);
    chk("s1_sel", 32'(o_select),    32'h04);
    chk("s1_bsy", 32'(o_busy),      32'h1);
    tick();
    chk("s1_drv_pulse", 32'(o_driveNext), 32'h0);
    chk("s1_sel_hold",  32'(o_select),    32'h04);
    repeat (2) tick();
    chk("s1_hold_late", 32'(o_select), 32'h04);
    free_grant("s1", 5'b00100);
    tick();
    chk_idle("s1_after");

    // All five ports at once: served in order 0..4
    do_reset();
    i_drive = 5'b11111;
    tick();
    i_drive = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("all_drv%0d", k), 32'(o_driveNext), 32'h1);
      chk($sformatf("all_sel%0d", k), 32'(o_select),    32'(1 << k));
      free_grant($sformatf("all%0d", k), 5'(1 << k));
      tick();
    end
    chk_idle("all_end");
    chk("all_err", 32'(o_err), 32'h0);

    // Fairness: port 0 re-drives in its o_free cycle while port 3 waits
    do_reset();
    i_drive = 5'b01001;
    tick();
    i_drive = '0;
    tick();
    chk("fair_g0", 32'(o_select), 32'h01);
    free_grant("fair_a", 5'b00001);
    i_drive = 5'b00001;
    tick();
    i_drive = '0;
    chk("fair_g3", 32'(o_select),    32'h08);
    chk("fair_d3", 32'(o_driveNext), 32'h1);
    free_grant("fair_b", 5'b01000);
    tick();
    chk("fair_g0b", 32'(o_select), 32'h01);
    free_grant("fair_c", 5'b00001);
    tick();
    chk_idle("fair_end");
    chk("fair_err", 32'(o_err), 32'h0);

    // Violation: second drive on port 1 before its free
    do_reset();
    i_drive = 5'b00010;
    tick();
    chk("v1_err_pre", 32'(o_err), 32'h0);
    tick();
    i_drive = '0;
    chk("v1_err", 32'(o_err),    32'h1);
    chk("v1_sel", 32'(o_select), 32'h02);
    free_grant("v1", 5'b00010);
    tick();
    chk_idle("v1_no_regrant");
    chk("v1_err_sticky", 32'(o_err), 32'h1);

    // Violation: free while idle
    do_reset();
    i_freeNext = 1'b1;
    tick();
    i_freeNext = 1'b0;
    chk("v2_err",  32'(o_err),  32'h1);
    chk("v2_free", 32'(o_free), 32'h0);
    tick();
    chk_idle("v2_idle");

    // Asynchronous reset while port 2 is granted
    do_reset();
    i_drive = 5'b00100;
    tick();
    i_drive = '0;
    tick();
    chk("rw_sel", 32'(o_select), 32'h04);
    #2 rstn = 1'b0;
    #1;
    chk_idle("rw_async");
    chk("rw_err", 32'(o_err), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    i_drive = 5'b10000;
    tick();
    i_drive = '0;
    chk("rw_lat", 32'(o_driveNext), 32'h0);
    tick();
    chk("rw_drv", 32'(o_driveNext), 32'h1);
    chk("rw_sel4", 32'(o_select),   32'h10);
    chk("rw_free_none", 32'(o_free), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
